gyro_spi_reader: RTL

- Upstream feeder for the display path. Talks to the PmodGYRO (L3G4200D) over 4-wire SPI, mode 3.
- After reset, issues one configuration write. Then polls temperature, status and the X/Y/Z axis registers with a single auto-increment burst read at a fixed rate.
- Presents `temp_data`, `x_axis`, `y_axis` and `z_axis` as stable registered words, updated atomically and flagged by a one-cycle `data_valid` pulse.
- The display controller consumes these words directly.

---
 rtl/gyro_pkg.sv | 23 ++
 rtl/spi_byte_engine.sv | 115 +++++++++++
 rtl/gyro_spi_reader.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/gyro_pkg.sv
// Shared constants and state encodings for the PmodGYRO (L3G4200D) SPI reader.
package gyro_pkg;

  localparam logic [7:0] CTRL_REG1  = 8'h20;
  localparam logic [7:0] OUT_TEMP   = 8'h26;
  localparam int         RW_BIT     = 7;
  localparam int         MS_BIT     = 6;
  localparam int         READ_BYTES = 8;

  typedef enum logic [2:0] {S_RESET, S_CFG, S_WAIT, S_READ, S_UPDATE} state_e;
  typedef enum logic [1:0] {PH_SETUP, PH_XFER, PH_HOLD} phase_e;
  typedef enum logic [1:0] {E_IDLE, E_LOW, E_HIGH} eng_state_e;

  // Read command with auto-increment so one burst walks temp..ZH.
  function automatic logic [7:0] burst_read_cmd(input logic [7:0] addr);
    logic [7:0] cmd;
    cmd         = addr;
    cmd[RW_BIT] = 1'b1;
    cmd[MS_BIT] = 1'b1;
    return cmd;
  endfunction

endpackage

// File: rtl/spi_byte_engine.sv
// Mode-3 SPI byte shifter: sclk low then high for CLK_DIV cycles per bit, MSB first.
// A start accepted in the final high cycle chains the next byte with no idle gap.
module spi_byte_engine
  import gyro_pkg::*;
#(
  parameter int CLK_DIV = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       preload,
  input  logic [7:0] tx_byte,
  input  logic       miso,
  output logic       sclk,
  output logic       mosi,
  output logic       done,
  output logic [7:0] rx_byte
);

  localparam int DW = $clog2(CLK_DIV);

  eng_state_e    state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    tx_sh_q, tx_sh_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic          sclk_q, sclk_d;
  logic          mosi_q, mosi_d;
  logic          div_end;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    tx_sh_d = tx_sh_q;
    rx_sh_d = rx_sh_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    div_end = (div_q == DW'(CLK_DIV - 1));
    done    = (state_q == E_HIGH) && div_end && (bit_q == 3'd7);

    unique case (state_q)
      E_IDLE: begin
        if (start) begin
          state_d = E_LOW;
          sclk_d  = 1'b0;
          mosi_d  = tx_byte[7];
          tx_sh_d = {tx_byte[6:0], 1'b0};
          div_d   = '0;
          bit_d   = '0;
        end else if (preload) begin
          mosi_d = tx_byte[7];
        end
      end
      E_LOW: begin
        div_d = div_q + 1'b1;
        if (div_end) begin
          state_d = E_HIGH;
          sclk_d  = 1'b1;
          div_d   = '0;
          rx_sh_d = {rx_sh_q[6:0], miso};
        end
      end
      E_HIGH: begin
        div_d = div_q + 1'b1;
        if (div_end) begin
          div_d = '0;
          if (bit_q != 3'd7) begin
            state_d = E_LOW;
            sclk_d  = 1'b0;
            bit_d   = bit_q + 1'b1;
            mosi_d  = tx_sh_q[7];
            tx_sh_d = {tx_sh_q[6:0], 1'b0};
          end else if (start) begin
            state_d = E_LOW;
            sclk_d  = 1'b0;
            bit_d   = '0;
            mosi_d  = tx_byte[7];
            tx_sh_d = {tx_byte[6:0], 1'b0};
          end else begin
            state_d = E_IDLE;
          end
        end
      end
      default: state_d = E_IDLE;
    endcase
  end

  // NOTE: sequential state uses <= only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= E_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      tx_sh_q <= '0;
      rx_sh_q <= '0;
      sclk_q  <= 1'b1;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      tx_sh_q <= tx_sh_d;
      rx_sh_q <= rx_sh_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
    end
  end

  assign sclk    = sclk_q;
  assign mosi    = mosi_q;
  assign rx_byte = rx_sh_q;

endmodule

// File: rtl/gyro_spi_reader.sv
// PmodGYRO poller: one CTRL_REG1 write after reset, then periodic 8-byte burst
// reads published atomically with a one-cycle data_valid pulse.
module gyro_spi_reader
  import gyro_pkg::*;
#(
  parameter int         CLK_DIV     = 50,
  parameter int         POLL_CYCLES = 10_000_000,
  parameter logic [7:0] CFG_VALUE   = 8'h0F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        miso,
  output logic        ss,
  output logic        sclk,
  output logic        mosi,
  output logic [7:0]  temp_data,
  output logic [7:0]  status,
  output logic [15:0] x_axis,
  output logic [15:0] y_axis,
  output logic [15:0] z_axis,
  output logic        data_valid,
  output logic        busy
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int PW = $clog2(POLL_CYCLES);
  localparam int GW = $clog2(2 * CLK_DIV);

  state_e        state_q, state_d;
  phase_e        phase_q, phase_d;
  logic [DW-1:0] cnt_q, cnt_d;
  logic [3:0]    idx_q, idx_d;
  logic [PW-1:0] poll_q, poll_d;
  logic [GW-1:0] gap_q, gap_d;
  logic          pend_q, pend_d;
  logic          ss_q, ss_d;
  logic          dv_q, dv_d;
  logic [7:0]    temp_q, temp_d, status_q, status_d;
  logic [15:0]   x_q, x_d, y_q, y_d, z_q, z_d;
  logic [7:0]    shadow_q [READ_BYTES];

  logic       eng_start, eng_preload, eng_done, shadow_we, begin_xact;
  logic       cnt_end, poll_hit, gap_ok;
  logic [3:0] byte_sel, last_idx;
  logic [2:0] shadow_idx;
  logic [7:0] tx_byte, eng_rx;

  spi_byte_engine #(.CLK_DIV(CLK_DIV)) u_engine (
    .clk     (clk),
    .rst     (rst),
    .start   (eng_start),
    .preload (eng_preload),
    .tx_byte (tx_byte),
    .miso    (miso),
    .sclk    (sclk),
    .mosi    (mosi),
    .done    (eng_done),
    .rx_byte (eng_rx)
  );

  always_comb begin
    byte_sel = (phase_q == PH_XFER) ? idx_q + 4'd1 : 4'd0;
    if (state_q == S_RESET || state_q == S_CFG)
      tx_byte = (byte_sel == 4'd0) ? CTRL_REG1 : CFG_VALUE;
    else
      tx_byte = (byte_sel == 4'd0) ? burst_read_cmd(OUT_TEMP) : 8'h00;
  end

  always_comb begin
    state_d  = state_q;   phase_d  = phase_q;  cnt_d = cnt_q;  idx_d = idx_q;
    poll_d   = poll_q;    pend_d   = pend_q;   gap_d = gap_q;  ss_d  = ss_q;
    temp_d   = temp_q;    status_d = status_q;
    x_d      = x_q;       y_d      = y_q;      z_d   = z_q;    dv_d  = 1'b0;
    eng_start   = 1'b0;
    eng_preload = 1'b0;
    shadow_we   = 1'b0;
    begin_xact  = 1'b0;
    shadow_idx  = 3'(idx_q - 4'd1);
    cnt_end  = (cnt_q == DW'(CLK_DIV - 1));
    poll_hit = (poll_q == PW'(POLL_CYCLES - 1));
    gap_ok   = (gap_q == GW'(2 * CLK_DIV - 1));
    last_idx = (state_q == S_CFG) ? 4'd1 : 4'(READ_BYTES);

    if (ss_q && !gap_ok) gap_d = gap_q + 1'b1;
    // Poll period runs free once configured, so read starts stay on a fixed grid.
    if (state_q inside {S_WAIT, S_READ, S_UPDATE}) begin
      poll_d = poll_hit ? '0 : poll_q + 1'b1;
      if (poll_hit) pend_d = 1'b1;
    end

    unique case (state_q)
      S_RESET: begin
        state_d    = S_CFG;
        begin_xact = 1'b1;
      end
      S_CFG, S_READ: begin
        unique case (phase_q)
          PH_SETUP: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_end) begin
              cnt_d     = '0;
              eng_start = 1'b1;
              phase_d   = PH_XFER;
            end
          end
          PH_XFER: begin
            if (eng_done) begin
              shadow_we = (state_q == S_READ) && (idx_q != 4'd0);
              if (idx_q != last_idx) begin
                eng_start = 1'b1;
                idx_d     = idx_q + 4'd1;
              end else begin
                phase_d = PH_HOLD;
                cnt_d   = '0;
              end
            end
          end
          PH_HOLD: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_end) begin
              cnt_d = '0;
              ss_d  = 1'b1;
              gap_d = '0;
              if (state_q == S_CFG) begin
                state_d = S_WAIT;
                poll_d  = '0;
                pend_d  = 1'b0;
              end else begin
                state_d = S_UPDATE;
              end
            end
          end
          default: phase_d = PH_SETUP;
        endcase
      end
      S_UPDATE: begin
        temp_d   = shadow_q[0];
        status_d = shadow_q[1];
        x_d      = {shadow_q[3], shadow_q[2]};
        y_d      = {shadow_q[5], shadow_q[4]};
        z_d      = {shadow_q[7], shadow_q[6]};
        dv_d     = 1'b1;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        if ((poll_hit || pend_q) && gap_ok) begin
          state_d    = S_READ;
          begin_xact = 1'b1;
        end
      end
      default: state_d = S_RESET;
    endcase

    if (begin_xact) begin
      ss_d        = 1'b0;
      phase_d     = PH_SETUP;
      cnt_d       = '0;
      idx_d       = '0;
      pend_d      = 1'b0;
      eng_preload = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RESET;  phase_q  <= PH_SETUP;  cnt_q <= '0;  idx_q <= '0;
      poll_q  <= '0;       pend_q   <= 1'b0;      gap_q <= '0;  ss_q  <= 1'b1;
      temp_q  <= '0;       status_q <= '0;
      x_q     <= '0;       y_q      <= '0;        z_q   <= '0;  dv_q  <= 1'b0;
    end else begin
      state_q <= state_d;  phase_q  <= phase_d;   cnt_q <= cnt_d;  idx_q <= idx_d;
      poll_q  <= poll_d;   pend_q   <= pend_d;    gap_q <= gap_d;  ss_q  <= ss_d;
      temp_q  <= temp_d;   status_q <= status_d;
      x_q     <= x_d;      y_q      <= y_d;       z_q   <= z_d;    dv_q  <= dv_d;
    end
  end

  // NOTE: shadow bytes need no reset; a full read rewrites all of them before any UPDATE.
  always_ff @(posedge clk) begin
    if (shadow_we) shadow_q[shadow_idx] <= eng_rx;
  end

  assign ss         = ss_q;
  assign busy       = ~ss_q;
  assign data_valid = dv_q;
  assign temp_data  = temp_q;
  assign status     = status_q;
  assign x_axis     = x_q;
  assign y_axis     = y_q;
  assign z_axis     = z_q;

endmodule
